// File: rtl/beat_generator.sv
// Metronome strobe generator: converts a BPM request into cycles-per-tick with an
// iterative restoring divider, then emits tick/beat/downbeat strobes at that period.
module beat_generator #(
  parameter int CLK_HZ            = 200_000_000,
  parameter int SUBDIV            = 4,
  parameter int BEATS_PER_MEASURE = 4,
  parameter int MIN_BPM           = 40,
  parameter int MAX_BPM           = 255
) (
  input  logic                                 clk_camera_in,
  input  logic                                 rst_in,
  input  logic                                 enable_in,
  input  logic [7:0]                           bpm_in,
  input  logic                                 sync_in,
  output logic                                 tick_out,
  output logic                                 beat_out,
  output logic                                 downbeat_out,
  output logic [$clog2(BEATS_PER_MEASURE)-1:0] beat_idx_out,
  output logic [31:0]                          period_out,
  output logic                                 busy_out
);

  localparam int          SW       = (SUBDIV > 1) ? $clog2(SUBDIV) : 1;
  localparam int          BW       = $clog2(BEATS_PER_MEASURE);
  localparam logic [39:0] DIVIDEND = 40'(CLK_HZ) * 40'd60;
  localparam logic [8:0]  MIN_B    = 9'(MIN_BPM);
  localparam logic [8:0]  MAX_B    = 9'(MAX_BPM);

  typedef enum logic [1:0] {DIV_IDLE, DIV_RUN, DIV_DONE} div_state_t;

  div_state_t  div_state, div_next;
  logic [7:0]  bpm_eff, bpm_cur;
  logic [39:0] divisor, rem, quo, rem_nxt;
  logic [40:0] trial;
  logic        q_bit, div_start;
  logic [5:0]  bit_cnt;
  logic [31:0] pend_period;
  logic        pending_valid;

  logic [31:0] phase_cnt;
  logic [SW-1:0] sub_cnt;
  logic        run_q, running, restart, nat_tick, sub_wrap, beat_wrap, adopt;

  always_comb begin
    bpm_eff = bpm_in;
    if ({1'b0, bpm_in} < MIN_B)      bpm_eff = MIN_B[7:0];
    else if ({1'b0, bpm_in} > MAX_B) bpm_eff = MAX_B[7:0];
  end

  // One restoring step: shift the next dividend bit into the partial remainder.
  always_comb begin
    trial   = {rem, quo[39]};
    q_bit   = trial >= {1'b0, divisor};
    rem_nxt = q_bit ? 40'(trial - {1'b0, divisor}) : trial[39:0];
  end

  assign div_start = (div_state == DIV_IDLE) && (bpm_eff != bpm_cur);

  always_ff @(posedge clk_camera_in) begin
    if (!rst_in) div_state <= DIV_IDLE;
    else         div_state <= div_next;
  end

  always_comb begin
    div_next = div_state;
    case (div_state)
      DIV_IDLE: if (div_start) div_next = DIV_RUN;
      DIV_RUN:  if (bit_cnt == 6'd39) div_next = DIV_DONE;
      DIV_DONE: div_next = DIV_IDLE;
      default:  div_next = DIV_IDLE;
    endcase
  end

  always_ff @(posedge clk_camera_in) begin
    if (!rst_in) begin
      bpm_cur       <= '0;
      divisor       <= '0;
      rem           <= '0;
      quo           <= '0;
      bit_cnt       <= '0;
      pend_period   <= '0;
      pending_valid <= 1'b0;
    end else begin
      if (div_start) begin
        bpm_cur <= bpm_eff;
        divisor <= 40'(bpm_eff) * 40'(SUBDIV);
        rem     <= '0;
        quo     <= DIVIDEND;
        bit_cnt <= '0;
      end else if (div_state == DIV_RUN) begin
        rem     <= rem_nxt;
        quo     <= {quo[38:0], q_bit};
        bit_cnt <= bit_cnt + 6'd1;
      end
      // A fresh result wins over an adoption on the same edge.
      if (div_state == DIV_DONE) begin
        pend_period   <= (quo == '0) ? 32'd1 : quo[31:0];
        pending_valid <= 1'b1;
      end else if (adopt) begin
        pending_valid <= 1'b0;
      end
    end
  end

  assign busy_out  = (div_state != DIV_IDLE) || pending_valid;

  assign running   = enable_in && ((period_out != '0) || pending_valid);
  assign restart   = running && (!run_q || sync_in);
  assign nat_tick  = phase_cnt == 32'(period_out - 32'd1);
  assign sub_wrap  = sub_cnt == SW'(SUBDIV - 1);
  assign beat_wrap = beat_idx_out == BW'(BEATS_PER_MEASURE - 1);
  // New periods land only where a beat starts, keeping each beat uniform.
  assign adopt     = pending_valid && (restart || (running && nat_tick && sub_wrap));

  always_ff @(posedge clk_camera_in) begin
    if (!rst_in) begin
      tick_out     <= 1'b0;
      beat_out     <= 1'b0;
      downbeat_out <= 1'b0;
      beat_idx_out <= '0;
      period_out   <= '0;
      phase_cnt    <= '0;
      sub_cnt      <= '0;
      run_q        <= 1'b0;
    end else begin
      tick_out     <= 1'b0;
      beat_out     <= 1'b0;
      downbeat_out <= 1'b0;
      run_q        <= running;
      if (adopt) period_out <= pend_period;
      if (!enable_in) begin
        phase_cnt    <= '0;
        sub_cnt      <= '0;
        beat_idx_out <= '0;
      end else if (restart) begin
        phase_cnt    <= '0;
        sub_cnt      <= '0;
        beat_idx_out <= '0;
        tick_out     <= 1'b1;
        beat_out     <= 1'b1;
        downbeat_out <= 1'b1;
      end else if (running) begin
        if (nat_tick) begin
          phase_cnt <= '0;
          tick_out  <= 1'b1;
          if (sub_wrap) begin
            sub_cnt      <= '0;
            beat_out     <= 1'b1;
            beat_idx_out <= beat_wrap ? '0 : BW'(beat_idx_out + BW'(1));
            downbeat_out <= beat_wrap;
          end else begin
            sub_cnt <= SW'(sub_cnt + SW'(1));
          end
        end else begin
          phase_cnt <= phase_cnt + 32'd1;
        end
      end
    end
  end

endmodule

// File: tb/tb_beat_generator.sv
// Bench for beat_generator at CLK_HZ=1000: period table, hand-written corner
// sequences, and randomized tempo/sync runs checked against a tick-count model.
module tb_beat_generator;
  localparam int CLK_HZ = 1000;
  localparam int SUBDIV = 4;
  localparam int BPMEAS = 4;

  logic        clk = 1'b0;
  logic        rst_n, en, sync;
  logic [7:0]  bpm;
  logic        tick, beat, down, busy;
  logic [1:0]  idx;
  logic [31:0] period;

  beat_generator #(.CLK_HZ(CLK_HZ), .SUBDIV(SUBDIV), .BEATS_PER_MEASURE(BPMEAS),
                   .MIN_BPM(40), .MAX_BPM(255)) dut (
    .clk_camera_in(clk), .rst_in(rst_n), .enable_in(en), .bpm_in(bpm),
    .sync_in(sync), .tick_out(tick), .beat_out(beat), .downbeat_out(down),
    .beat_idx_out(idx), .period_out(period), .busy_out(busy)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: ticks counted since the last start/sync, cycles since the last tick.
  int m_p, m_pend_p, m_c, m_k;
  bit m_pend, m_tick, m_beat, m_down;
  int m_idx;

  typedef struct { int b; int exp_p; } vec_t;
  vec_t vecs[$];

  function automatic int ref_period(int b);
    int e = (b < 40) ? 40 : ((b > 255) ? 255 : b);
    int q = (CLK_HZ * 60) / (e * SUBDIV);
    return (q < 1) ? 1 : q;
  endfunction

  task automatic check(string name, longint act, longint exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic model_start(int p);
    m_p = p; m_pend = 0; m_c = 0; m_k = 0;
    m_tick = 1; m_beat = 1; m_down = 1; m_idx = 0;
  endtask

  task automatic model_step(bit s);
    m_tick = 0;
    if (s) begin
      m_c = 0; m_k = 0; m_tick = 1;
      if (m_pend) begin m_p = m_pend_p; m_pend = 0; end
    end else begin
      m_c++;
      if (m_c == m_p) begin
        m_c = 0; m_k++; m_tick = 1;
        if ((m_k % SUBDIV) == 0 && m_pend) begin m_p = m_pend_p; m_pend = 0; end
      end
    end
    m_beat = m_tick && (m_k % SUBDIV) == 0;
    m_down = m_tick && (m_k % (SUBDIV * BPMEAS)) == 0;
    m_idx  = (m_k / SUBDIV) % BPMEAS;
  endtask

  task automatic run_model(int cycles, bit rnd_sync);
    for (int i = 0; i < cycles; i++) begin
      bit s = rnd_sync && ($urandom_range(0, 299) == 0);
      sync = s;
      step();
      sync = 1'b0;
      model_step(s);
      check("strobes", {tick, beat, down, idx, period},
            {m_tick, m_beat, m_down, 2'(m_idx), 32'(m_p)});
    end
  endtask

  task automatic wait_tick(int limit, output int busy_cnt);
    int t = 0;
    busy_cnt = 0;
    while (!tick && t < limit) begin
      if (busy) busy_cnt++;
      step();
      t++;
    end
    if (!tick) begin
      n_checks++; n_fail++;
      $display("FAIL tick_timeout: no tick within %0d cycles", limit);
    end
  endtask

  initial begin
    int bc, guard;
    vecs = '{'{60, 250}, '{10, 375}, '{255, 58}, '{40, 375}, '{39, 375},
             '{120, 125}, '{200, 75}, '{0, 375}, '{41, 365}, '{100, 150}, '{250, 60}};

    rst_n = 1'b0; en = 1'b1; bpm = 8'd60; sync = 1'b0;
    repeat (3) step();
    check("reset", {tick, beat, down, idx, period, busy}, 38'd0);

    // Power-up at 60 bpm: division latency then a start strobe set.
    rst_n = 1'b1;
    wait_tick(100, bc);
    check("busy_len_ge_41", bc >= 41, 1);
    check("first_start", {tick, beat, down, idx, period}, {3'b111, 2'd0, 32'd250});
    check("busy_after_adopt", busy, 0);
    model_start(250);
    run_model(4100, 1'b0);

    // Sync landing on a natural (non-beat) tick gives one full strobe set.
    guard = 0;
    while (!(m_c == m_p - 1 && (m_k % SUBDIV) == 1) && guard < 2000) begin
      run_model(1, 1'b0); guard++;
    end
    sync = 1'b1; step(); sync = 1'b0; model_step(1'b1);
    check("sync_on_tick", {tick, beat, down, idx}, {3'b111, 2'd0});
    run_model(260, 1'b0);

    // Tempo change mid-beat: period holds until the next beat edge.
    guard = 0;
    while (!(m_c == 0 && (m_k % SUBDIV) == 2) && guard < 2000) begin
      run_model(1, 1'b0); guard++;
    end
    bpm = 8'd120; m_pend = 1; m_pend_p = 125;
    run_model(1200, 1'b0);
    check("period_after_change", period, 125);

    // Enable low mid-measure, then high.
    guard = 0;
    while (!((m_k % 16) == 6 && m_c == 10) && guard < 3000) begin
      run_model(1, 1'b0); guard++;
    end
    en = 1'b0; step();
    check("stop_cleared", {tick, beat, down, idx}, 5'd0);
    for (int i = 0; i < 20; i++) begin
      step();
      check("stopped_quiet", {tick, beat, down, idx}, 5'd0);
    end
    check("stopped_period_kept", period, 125);
    en = 1'b1; step();
    check("restart", {tick, beat, down, idx}, {3'b111, 2'd0});
    model_start(125);
    run_model(600, 1'b0);

    foreach (vecs[v]) begin
      en = 1'b0; bpm = 8'(vecs[v].b);
      repeat (50) step();
      en = 1'b1; step();
      check($sformatf("vec_period_bpm%0d", vecs[v].b), period, vecs[v].exp_p);
      check("vec_start", {tick, beat, down, idx}, {3'b111, 2'd0});
    end

    for (int seg = 0; seg < 5; seg++) begin
      int b = $urandom_range(0, 255);
      en = 1'b0; bpm = 8'(b);
      repeat (50) step();
      en = 1'b1; step();
      check($sformatf("rand_period_bpm%0d", b), period, ref_period(b));
      model_start(ref_period(b));
      run_model(1500, 1'b1);
    end

    // Reset in the middle of a division.
    en = 1'b0; bpm = 8'd60;
    repeat (50) step();
    bpm = 8'd200;
    repeat (10) step();
    check("busy_in_run", busy, 1);
    rst_n = 1'b0; step();
    check("reset_mid_div", {tick, beat, down, idx, period, busy}, 38'd0);
    rst_n = 1'b1; en = 1'b1;
    wait_tick(100, bc);
    check("period_after_reset", period, 75);
    model_start(75);
    run_model(400, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
